// File: rtl/rr_mux4_stream.sv
// rtl/rr_mux4_stream.sv - 4-to-1 round-robin valid/ready stream merge with channel tag
module rr_mux4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [1:0]       last_grant;
    logic             load;
    logic             grant_found;
    logic [1:0]       grant_idx;
    logic [WIDTH-1:0] grant_data;

    // The output register may take a new word when it is empty or being drained this cycle.
    assign load = !out_valid || out_ready;

    // Rotating-priority search starting just after the previous winner; the sum wraps mod 4.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        for (int i = 1; i <= 4; i++) begin
            if (!grant_found && in_valid[last_grant + 2'(i)]) begin
                grant_found = 1'b1;
                grant_idx   = last_grant + 2'(i);
            end
        end
    end

    // Ready is one-hot on the winner, suppressed under backpressure and while reset is held.
    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && load && grant_found) begin
            in_ready = 4'b0001 << grant_idx;
        end
    end

    // Data path select for the winning channel; ready never looks at this.
    always_comb begin
        grant_data = in_data[int'(grant_idx) * WIDTH +: WIDTH];
    end

    // Output register and arbitration history; holds everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= 2'd0;
            last_grant <= 2'd3;
        end else if (load) begin
            if (grant_found) begin
                out_valid  <= 1'b1;
                out_data   <= grant_data;
                out_sel    <= grant_idx;
                last_grant <= grant_idx;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4_stream.sv
// tb/tb_rr_mux4_stream.sv - scoreboard bench for rr_mux4_stream
module tb_rr_mux4_stream;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [4*WIDTH-1:0] in_data = '0;
    logic [3:0]         in_valid = 4'b0000;
    logic [3:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_valid;
    logic               out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [WIDTH+1:0] exp_q[$];
    int               m_last = 3;
    bit               m_full = 1'b0;

    always #5 clk = ~clk;

    rr_mux4_stream #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_sel(out_sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid channel after the last winner, going round 4 positions; -1 if none.
    function automatic int winner(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Drive one cycle of stimulus, check ready against the model and record any expected word.
    task automatic step(input logic [3:0] v, input logic r, input logic [31:0] d, input bit wait_edge);
        int         g;
        bit         ld;
        logic [3:0] exp_rdy;
        if (wait_edge) @(posedge clk);
        #2;
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        #1;
        ld      = !m_full || r;
        g       = winner(v, m_last);
        exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (ld) begin
            if (g >= 0) begin
                exp_q.push_back({2'(g), d[g*WIDTH +: WIDTH]});
                m_last = g;
                m_full = 1'b1;
            end else begin
                m_full = 1'b0;
            end
        end
    endtask

    // Monitor: pop and compare on every output handshake; check stability across stalls.
    initial begin
        logic [WIDTH+1:0] e;
        bit               stall_prev;
        logic [WIDTH-1:0] prev_d;
        logic [1:0]       prev_s;
        stall_prev = 1'b0;
        prev_d = '0;
        prev_s = '0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (stall_prev) begin
                    chk("hold_data", 32'(out_data), 32'(prev_d));
                    chk("hold_sel", 32'(out_sel), 32'(prev_s));
                end
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected actual=sel%0d/%0h required=no word at %0t", out_sel, out_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e[WIDTH-1:0] || out_sel !== e[WIDTH+1:WIDTH]) begin
                            failures++;
                            $display("FAIL out_word actual=sel%0d/%0h required=sel%0d/%0h at %0t",
                                     out_sel, out_data, e[WIDTH+1:WIDTH], e[WIDTH-1:0], $time);
                        end
                    end
                end
                stall_prev = !out_ready;
                prev_d = out_data;
                prev_s = out_sel;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    localparam logic [31:0] PAT_A = 32'hA3A2A1A0;
    localparam logic [31:0] PAT_C = 32'h005C0000;

    initial begin
        #1 rst_n = 1'b0;
        in_valid = 4'b1111;
        in_data  = PAT_A;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'b1111, 1'b1, PAT_A, 1'b0);
        repeat (7) step(4'b1111, 1'b1, PAT_A, 1'b1);

        repeat (4) step(4'b0100, 1'b1, PAT_C, 1'b1);

        step(4'b1111, 1'b1, PAT_A, 1'b1);
        step(4'b1111, 1'b1, PAT_A, 1'b1);
        step(4'b0010, 1'b1, PAT_A, 1'b1);
        repeat (3) step(4'b1111, 1'b0, PAT_A, 1'b1);
        step(4'b1111, 1'b1, PAT_A, 1'b1);

        step(4'b0010, 1'b1, 32'h11223344, 1'b1);
        step(4'b1001, 1'b1, 32'h55667788, 1'b1);
        step(4'b1001, 1'b1, 32'h99AABBCC, 1'b1);

        step(4'b1111, 1'b0, PAT_A, 1'b1);
        step(4'b1111, 1'b0, PAT_A, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        in_valid = 4'b0000;
        exp_q.delete();
        m_last = 3;
        m_full = 1'b0;
        #2 rst_n = 1'b1;
        step(4'b1111, 1'b1, PAT_A, 1'b1);
        step(4'b1111, 1'b1, PAT_A, 1'b1);

        for (int n = 0; n < 400; n++) begin
            step(4'($urandom_range(0, 15)), ($urandom % 4) != 0, $urandom, 1'b1);
        end

        repeat (4) step(4'b0000, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux4_stream.md
Name: rr_mux4_stream

Overview:
- 4-to-1 streaming multiplexer with round-robin arbitration.
- It is the merge side of the 1-to-4 demultiplexer path: four independent valid/ready producers are funnelled onto one registered output channel.
- The output carries a channel tag (out_sel) so the downstream demux can route each word back by index.
- Sits between the per-channel sources and the shared output link.

Parameters:
WIDTH, 8, data width of every input channel and of the output.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_data  input  4*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
in_valid  input  4  per-channel valid, bit k = channel k.
in_ready  output  4  per-channel ready, at most one bit high per cycle.
out_data  output  WIDTH  registered merged data.
out_sel  output  2  registered index of the channel that supplied out_data.
out_valid  output  1  registered output valid.
out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock required):
  - out_valid=0, out_data=0, out_sel=0.
  - last_grant=3, so channel 0 has first priority after release.
  - in_ready=0000 while rst_n=0.
- Output register state, implied by out_valid: EMPTY (out_valid=0) or FULL (out_valid=1).
- Load enable: load = (!out_valid) | out_ready.
- Arbitration (combinational):
  - Only when load=1 and in_valid!=0.
  - Search order is last_grant+1, +2, +3, +4 (mod 4); the first channel with in_valid set wins (g).
  - in_ready[g]=1; all other in_ready bits are 0.
  - If load=0, in_ready=0000.
  - in_ready may depend combinationally on in_valid, out_valid, out_ready and last_grant. It must not depend on in_data.
- On a rising edge with load=1 and a grant g:
  - out_data<=in_data[g], out_sel<=g, out_valid<=1, last_grant<=g.
  - Latency from input handshake to out_valid is exactly 1 cycle.
- On a rising edge with load=1 and no input valid:
  - out_valid<=0.
  - out_data, out_sel and last_grant hold.
- On a rising edge with load=0 (FULL and out_ready=0):
  - All registers hold.
  - out_data and out_sel must stay stable while out_valid=1 and out_ready=0.
- Simultaneous output drain and new load in one cycle: the new word replaces the drained one. Throughput is 1 word per cycle while out_ready=1.
- Fairness:
  - The granted channel becomes lowest priority for the next arbitration.
  - With all four channels valid continuously and out_ready=1, the grant order is 0,1,2,3,0,... with no channel skipped.
- Wrap-around: index arithmetic is 2-bit modulo 4; last_grant=3 searches 0 first.
- A channel dropping in_valid before it is granted is legal. It simply loses its turn; no state is recorded for it.
- Reset asserted mid-transfer:
  - The pending output word is discarded, with no handshake completed.
  - After release, arbitration restarts from channel 0.

Test Plan:
- Reset with in_valid=1111 held, then release:
  - During reset: out_valid=0 and in_ready=0000.
  - First edge after release: in_ready=0001 and out_sel=0.
- All channels valid, in_data channel k = 8'hA0+k, out_ready=1 for 8 cycles:
  - out_data sequence A0,A1,A2,A3,A0,A1,A2,A3.
  - out_sel sequence 0,1,2,3,0,1,2,3.
  - out_valid=1 every cycle after the first.
- Only channel 2 valid (data 8'h5C), out_ready=1: in_ready=0100 every cycle, and out_data=5C with out_sel=2 on consecutive cycles.
- Backpressure: output FULL with out_data=A1, then out_ready=0 for 3 cycles with all channels valid:
  - out_data=A1 and out_sel=1 stable throughout, in_ready=0000.
  - On out_ready=1, the next word is A2 from channel 2.
- Priority wrap: last_grant=1, only channels 0 and 3 valid → channel 3 is granted first, then channel 0.
- rst_n pulsed low for 3 ns between clock edges while out_valid=1:
  - out_valid falls immediately, without waiting for a clock edge.
  - After release, channel 0 is granted first.
